// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to add the WAIT_BUSY timeout and arb_err pulse.
module uart_tx_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic                       tx_busy,
  output logic                       tx_data_valid,
  output logic [WIDTH-1:0]           tx_p_data,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       arb_idle
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                       arb_err
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || WIDTH < 1)
  begin : g_bad_param
    $error("uart_tx_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q;
`endif

  logic [WIDTH-1:0]   slot [NUM_REQ];
  logic [IW-1:0]      pick_d;
  logic               found_d;
  logic [IW:0]        cand;
  logic [NUM_REQ-1:0] onehot_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Search starts just after the last winner and wraps modulo NUM_REQ.
  always_comb begin
    pick_d  = '0;
    found_d = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (!found_d && req[cand[IW-1:0]]) begin
        found_d = 1'b1;
        pick_d  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    onehot_d         = '0;
    onehot_d[pick_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_q        <= IW'(NUM_REQ - 1);
      gnt           <= '0;
      tx_data_valid <= 1'b0;
      tx_p_data     <= '0;
      owner         <= '0;
      arb_idle      <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      arb_err       <= 1'b0;
`endif
    end else begin
      gnt           <= '0;
      tx_data_valid <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      arb_err       <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (found_d && !tx_busy) begin
            gnt           <= onehot_d;
            tx_data_valid <= 1'b1;
            tx_p_data     <= slot[pick_d];
            owner         <= pick_d;
            last_q        <= pick_d;
            arb_idle      <= 1'b0;
            state_q       <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Frame never started; give up but keep the pointer on this owner.
            state_q  <= IDLE;
            arb_idle <= 1'b1;
            arb_err  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q  <= IDLE;
            arb_idle <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          arb_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: random requests and busy profiles
// against a queue-based round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           tx_busy;
  logic           tx_data_valid;
  logic [W-1:0]   tx_p_data;
  logic [1:0]     owner;
  logic           arb_idle;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic           arb_err;
`endif

  uart_tx_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_p_data     (tx_p_data),
    .owner         (owner),
    .arb_idle      (arb_idle)
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    .arb_err       (arb_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  int         last   = N - 1;
  logic [7:0] hold_d = '0;
  int         hold_o = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(logic [3:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic expect_grant(logic [3:0] r, logic [31:0] d);
    exp_t e;
    e.idx  = pick(r);
    e.data = d[e.idx*8 +: 8];
    q.push_back(e);
    last = e.idx;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      hold_d = '0;
      hold_o = 0;
    end else if (gnt != '0 || tx_data_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_grant: gnt=%b valid=%b, none expected",
                 gnt, tx_data_valid);
      end else begin
        e = q.pop_front();
        chk("gnt", 32'(gnt), 32'(1) << e.idx);
        chk("data_valid", 32'(tx_data_valid), 32'd1);
        chk("p_data", 32'(tx_p_data), 32'(e.data));
        chk("owner", 32'(owner), 32'(e.idx));
        chk("idle_at_grant", 32'(arb_idle), 32'd0);
        hold_d = e.data;
        hold_o = e.idx;
      end
    end else begin
      chk("p_data_hold", 32'(tx_p_data), 32'(hold_d));
      chk("owner_hold", 32'(owner), 32'(hold_o));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    req      = 4'($urandom);
    req_data = $urandom;
  endtask

  task automatic launch(logic [3:0] r, logic [31:0] d);
    req      = r;
    req_data = d;
    expect_grant(r, d);
    tick();
    req = '0;
  endtask

  task automatic frame(int d1, int d2, logic [3:0] nr, logic [31:0] nd);
    tx_busy = 1'b0;
    repeat (d1 + 1) begin
      noise();
      tick();
    end
    tx_busy = 1'b1;
    for (int j = 0; j < d2; j++) begin
      noise();
      tick();
      if (j == 0) chk("busy_not_idle", 32'(arb_idle), 32'd0);
    end
    req      = nr;
    req_data = nd;
    tx_busy  = 1'b0;
    tick();
    chk("idle_after_busy_fall", 32'(arb_idle), 32'd1);
    if (nr != '0) begin
      expect_grant(nr, nd);
      tick();
      req = '0;
    end
  endtask

  initial begin
    logic [3:0]  r;
    logic [3:0]  nr;
    logic [31:0] d;
    bit          inflight;

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_p_data", 32'(tx_p_data), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_idle", 32'(arb_idle), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    launch(4'b0001, 32'h0000_00A5);
    frame(1, 4, '0, '0);

    launch(4'hF, 32'h4433_2211);
    repeat (4) frame(0, 3, 4'hF, 32'h4433_2211);
    frame(0, 2, '0, '0);

    launch(4'b0100, 32'hDEAD_BEEF);
    frame(2, 2, 4'b0101, 32'h1234_5678);
    frame(0, 2, '0, '0);

    tx_busy  = 1'b1;
    req      = 4'b0010;
    req_data = $urandom;
    repeat (3) tick();
    chk("held_off_by_busy", 32'(arb_idle), 32'd1);
    tx_busy = 1'b0;
    expect_grant(req, req_data);
    tick();
    req = '0;
    frame(1, 2, '0, '0);

    launch(4'b1000, $urandom);
`ifdef UART_TX_ARB_TIMEOUT_EN
    tick();
    repeat (6) begin
      tick();
      chk("no_err_yet", 32'(arb_err), 32'd0);
    end
    tick();
    chk("arb_err_pulse", 32'(arb_err), 32'd1);
    chk("idle_after_timeout", 32'(arb_idle), 32'd1);
    tick();
    chk("arb_err_clear", 32'(arb_err), 32'd0);
`else
    repeat (12) tick();
    chk("waits_for_busy", 32'(arb_idle), 32'd0);
    tx_busy = 1'b1;
    repeat (2) tick();
    tx_busy = 1'b0;
    tick();
    chk("idle_after_late_frame", 32'(arb_idle), 32'd1);
`endif

    launch(4'b0100, $urandom);
    tick();
    tx_busy = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(tx_data_valid), 32'd0);
    chk("midrst_p_data", 32'(tx_p_data), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    chk("midrst_idle", 32'(arb_idle), 32'd1);
    tx_busy = 1'b0;
    tick();
    rst  = 1'b1;
    last = N - 1;
    tick();
    launch(4'b1000, 32'hC3_00_00_00);
    frame(1, 2, '0, '0);

    inflight = 1'b0;
    for (int it = 0; it < 200; it++) begin
      if (!inflight) begin
        r = 4'($urandom_range(1, 15));
        d = $urandom;
        launch(r, d);
        inflight = 1'b1;
      end else begin
        nr = ($urandom % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        d  = $urandom;
        frame($urandom_range(0, 4), $urandom_range(1, 6), nr, d);
        inflight = (nr != '0);
      end
    end
    if (inflight) frame(1, 2, '0, '0);

    repeat (2) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
